// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC select codes and FSM states.
package pc_pkg;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_adder.sv
// Combinational modulo-2^ADDR_W adder; the carry out is intentionally dropped.
module pc_adder #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_a,
  input  logic [ADDR_W-1:0] i_b,
  output logic [ADDR_W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC select (seq/branch/jump/jr/exception),
// fetch valid/ready handshake, BOOT/RUN/HALT control and an accepted-fetch counter.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned redirect targets divert to the
// exception vector and pulse o_misalign.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          STEP      = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
  parameter int          CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_resume,
  input  logic              i_ctl_valid,
  input  logic [1:0]        i_sel,
  input  logic              i_taken,
  input  logic [ADDR_W-1:0] i_imm_off,
  input  logic [25:0]       i_jump_idx,
  input  logic [ADDR_W-1:0] i_jr_addr,
  input  logic              i_exc,
  input  logic              i_fetch_ready,
  output logic              o_fetch_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_next_seq,
  output logic [CNT_W-1:0]  o_fetch_cnt
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              o_misalign
`endif
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

  pc_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  seq_pc, br_pc, jmp_pc, target;
  logic [ADDR_W-1:0]  br_off;
  logic               accept, redirect;
`ifdef PC_ALIGN_CHECK_EN
  logic               misalign_q, misalign_d;
`endif

  assign br_off = {i_imm_off[ADDR_W-3:0], 2'b00};

  pc_adder #(.ADDR_W(ADDR_W)) u_seq_add (.i_a(pc_q),   .i_b(STEP_W), .o_sum(seq_pc));
  pc_adder #(.ADDR_W(ADDR_W)) u_br_add  (.i_a(seq_pc), .i_b(br_off), .o_sum(br_pc));

  assign jmp_pc        = {seq_pc[ADDR_W-1:28], i_jump_idx, 2'b00};
  assign o_fetch_valid = (state_q == ST_RUN) && !i_stall;
  assign accept        = o_fetch_valid && i_fetch_ready;
  assign o_pc          = pc_q;
  assign o_pc_next_seq = seq_pc;
  assign o_fetch_cnt   = cnt_q;

  // Redirect target select and qualification; only the running core steers the PC.
  always_comb begin
    target = seq_pc;
    case (i_sel)
      SEL_SEQ: target = seq_pc;
      SEL_BR:  target = br_pc;
      SEL_J:   target = jmp_pc;
      SEL_JR:  target = i_jr_addr;
    endcase
    redirect = i_ctl_valid && (state_q == ST_RUN) &&
               (((i_sel == SEL_BR) && i_taken) || i_sel[1]);
  end

  // Next PC by priority: exception, stall, redirect, accepted sequential, hold.
  always_comb begin
    pc_d = pc_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    if (i_exc) begin
      pc_d = EXC_PC;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
      if (target[1:0] != 2'b00) begin
        pc_d       = EXC_PC;
        misalign_d = 1'b1;
      end else begin
        pc_d = target;
      end
`else
      pc_d = target;
`endif
    end else if (accept) begin
      pc_d = seq_pc;
    end
  end

  // BOOT lasts one clock; halt/resume toggle RUN/HALT; an exception always lands in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (i_halt)   state_d = ST_HALT;
      ST_HALT: if (i_resume) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (i_exc) state_d = ST_RUN;
  end

  // Accepted-fetch counter, wraps naturally.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept);
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle misalignment pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end

  assign o_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, branch/jump/jr, stall, exception,
// halt/resume, PC wrap and (when PC_ALIGN_CHECK_EN is defined) misalignment.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, resume, ctl_valid, taken, exc, ready;
  logic [1:0]  sel;
  logic [31:0] imm_off, jr_addr, pc, pc_seq, cnt;
  logic [25:0] jump_idx;
  logic        fvalid;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt), .i_resume(resume),
    .i_ctl_valid(ctl_valid), .i_sel(sel), .i_taken(taken), .i_imm_off(imm_off),
    .i_jump_idx(jump_idx), .i_jr_addr(jr_addr), .i_exc(exc), .i_fetch_ready(ready),
    .o_fetch_valid(fvalid), .o_pc(pc), .o_pc_next_seq(pc_seq), .o_fetch_cnt(cnt)
`ifdef PC_ALIGN_CHECK_EN
    , .o_misalign(misalign)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; halt = 0; resume = 0; ctl_valid = 0; taken = 0;
    exc = 0; ready = 0; sel = SEL_SEQ; imm_off = '0; jr_addr = '0; jump_idx = '0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", fvalid, 1'b0);
    chk("rst_cnt", cnt, 32'h0);

    // 1. boot then sequential fetch
    ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("boot_valid", fvalid, 1'b0);
    tick(); chk("run_pc0", pc, 32'h0); chk("run_valid", fvalid, 1'b1);
    chk("pc_next_seq", pc_seq, 32'h4);
    tick(); chk("seq_pc4", pc, 32'h4); chk("cnt1", cnt, 32'd1);
    tick(); chk("seq_pc8", pc, 32'h8); chk("cnt2", cnt, 32'd2);

    // 2. branches
    ctl_valid = 1; sel = SEL_JR; jr_addr = 32'h100;
    tick(); chk("jr_100", pc, 32'h100); chk("cnt3", cnt, 32'd3);
    sel = SEL_BR; taken = 0; ready = 0;
    tick(); chk("br_nt_hold", pc, 32'h100); chk("cnt_hold", cnt, 32'd3);
    taken = 1; imm_off = 32'hFFFF_FFFE;
    tick(); chk("br_neg", pc, 32'hFC);

    // 3. jump / jump-register
    ready = 1; sel = SEL_JR; jr_addr = 32'h1000_0040;
    tick(); chk("jr_hi", pc, 32'h1000_0040);
    sel = SEL_J; jump_idx = 26'h10;
    tick(); chk("jump", pc, 32'h1000_0040);
    sel = SEL_JR; jr_addr = 32'h2000;
    tick(); chk("jr_2000", pc, 32'h2000); chk("cnt6", cnt, 32'd6);

    // 4. stall and exception
    stall = 1; sel = SEL_BR; taken = 1; imm_off = 32'h4; #1;
    chk("stall_valid", fvalid, 1'b0);
    tick(); chk("stall_pc", pc, 32'h2000); chk("stall_cnt", cnt, 32'd6);
    exc = 1;
    tick(); chk("stall_exc", pc, 32'h180);
    exc = 0; stall = 0; ctl_valid = 0; taken = 0;

    // 5. halt / resume
    halt = 1;
    tick(); chk("halt_pc", pc, 32'h184); chk("halt_valid", fvalid, 1'b0);
    halt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halt_frozen", pc, 32'h184); chk("halt_v0", fvalid, 1'b0);
    end
    halt = 1; resume = 1;
    tick(); chk("resume_valid", fvalid, 1'b1); chk("resume_pc", pc, 32'h184);
    resume = 0; ctl_valid = 1; sel = SEL_JR; jr_addr = 32'h300;
    tick(); chk("halt_redir_pc", pc, 32'h300); chk("halt_redir_v", fvalid, 1'b0);
    halt = 0; ctl_valid = 0; exc = 1;
    tick(); chk("halt_exc_pc", pc, 32'h180); chk("halt_exc_v", fvalid, 1'b1);
    chk("cnt8", cnt, 32'd8);
    exc = 0;

    // 6. wrap at top of address space
    ctl_valid = 1; sel = SEL_JR; jr_addr = 32'hFFFF_FFFC;
    tick(); chk("jr_top", pc, 32'hFFFF_FFFC);
    ctl_valid = 0;
    tick(); chk("wrap", pc, 32'h0); chk("cnt10", cnt, 32'd10);

`ifdef PC_ALIGN_CHECK_EN
    ctl_valid = 1; sel = SEL_JR; jr_addr = 32'h2002;
    tick(); chk("misalign_pc", pc, 32'h180); chk("misalign_hi", misalign, 1'b1);
    ctl_valid = 0;
    tick(); chk("misalign_lo", misalign, 1'b0);
`endif

    // async reset mid-operation, no clock edge needed
    @(negedge clk); rst_n = 0; #1;
    chk("async_pc", pc, 32'h0); chk("async_cnt", cnt, 32'h0); chk("async_v", fvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
